// File: rtl/z80_io_in_seq_if.sv
// Bus and operand bundle between the execute stage, the sequencer and the external bus interface.
interface z80_io_in_seq_if;
  logic        start;
  logic [2:0]  mode;
  logic [7:0]  n;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [7:0]  c_in;
  logic [15:0] hl_in;
  logic [7:0]  flags_in;
  logic        wait_n;
  logic        brk;
  logic [7:0]  io_rdata;
  logic [15:0] addr;
  logic        iorq;
  logic        rd;
  logic        wr;
  logic        mreq;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  data_out;
  logic [7:0]  b_out;
  logic [15:0] hl_out;
  logic [7:0]  flags_out;

  modport master (
    output start, mode, n, a_in, b_in, c_in, hl_in, flags_in, wait_n, brk, io_rdata,
    input  addr, iorq, rd, wr, mreq, wdata, busy, done, err, data_out, b_out, hl_out, flags_out
  );

  modport slave (
    input  start, mode, n, a_in, b_in, c_in, hl_in, flags_in, wait_n, brk, io_rdata,
    output addr, iorq, rd, wr, mreq, wdata, busy, done, err, data_out, b_out, hl_out, flags_out
  );
endinterface

// File: rtl/z80_io_in_seq.sv
// T-state sequencer for IN A,(n), IN r,(C), INI, IND, INIR and INDR.
// Drives the I/O read and memory write bus cycles and loops the repeat forms internally.
module z80_io_in_seq #(
  parameter int unsigned IO_WAIT = 1,
  parameter int unsigned RPT_T   = 5
) (
  input logic            clk,
  input logic            reset,
  z80_io_in_seq_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StIoT1, StIoT2, StIoTw, StIoT3, StMwT1, StMwT2, StMwT3, StRpt, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [15:0] port_q, port_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  c_q, c_d;
  logic [15:0] hl_q, hl_d;
  logic [7:0]  flags_q, flags_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [7:0]  b_dec;
  logic        last_tw;
  logic        io_ph;
  logic        io_strobe;
  logic        mw_ph;
  logic [15:0] io_addr;

  assign b_dec   = b_q - 8'd1;
  // True in the last counted wait state and in any WAIT-extended one after it.
  assign last_tw = (32'(cnt_q) + 32'd1) >= 32'(IO_WAIT);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    port_d  = port_q;
    b_d     = b_q;
    c_d     = c_q;
    hl_d    = hl_q;
    flags_d = flags_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          port_d  = {bus.a_in, bus.n};
          b_d     = bus.b_in;
          c_d     = bus.c_in;
          hl_d    = bus.hl_in;
          flags_d = bus.flags_in;
          err_d   = (bus.mode > 3'd5);
          state_d = (bus.mode > 3'd5) ? StDone : StIoT1;
        end
      end
      StIoT1: state_d = StIoT2;
      StIoT2: begin
        cnt_d   = '0;
        state_d = ((IO_WAIT != 0) || !bus.wait_n) ? StIoTw : StIoT3;
      end
      StIoTw: begin
        if (cnt_q != 4'hf) cnt_d = cnt_q + 4'd1;
        if (last_tw && bus.wait_n) state_d = StIoT3;
      end
      StIoT3: begin
        data_d = bus.io_rdata;
        if (mode_q == 3'd0) begin
          state_d = StDone;
        end else if (mode_q == 3'd1) begin
          flags_d = {bus.io_rdata[7], (bus.io_rdata == 8'h00), 1'b0, 1'b0, 1'b0,
                     ~^bus.io_rdata, 1'b0, flags_q[0]};
          state_d = StDone;
        end else begin
          state_d = StMwT1;
        end
      end
      StMwT1: state_d = StMwT2;
      StMwT2: begin
        if (bus.wait_n) state_d = StMwT3;
      end
      StMwT3: begin
        b_d  = b_dec;
        // mode bit 0 selects the decrementing forms (IND, INDR)
        hl_d = mode_q[0] ? (hl_q - 16'd1) : (hl_q + 16'd1);
        if (mode_q[2] && (b_dec != 8'h00) && !bus.brk) begin
          cnt_d   = '0;
          state_d = StRpt;
        end else begin
          flags_d = {b_dec[7], (b_dec == 8'h00), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, flags_q[0]};
          state_d = StDone;
        end
      end
      StRpt: begin
        if (cnt_q == 4'(RPT_T - 1)) state_d = StIoT1;
        else                        cnt_d   = cnt_q + 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= '0;
      port_q  <= '0;
      b_q     <= '0;
      c_q     <= '0;
      hl_q    <= '0;
      flags_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      port_q  <= port_d;
      b_q     <= b_d;
      c_q     <= c_d;
      hl_q    <= hl_d;
      flags_q <= flags_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from state so a reset drops them in the same cycle.
  always_comb begin
    io_ph     = (state_q == StIoT1) || (state_q == StIoT2) || (state_q == StIoTw) ||
                (state_q == StIoT3);
    io_strobe = (state_q == StIoT2) || (state_q == StIoTw) || (state_q == StIoT3);
    mw_ph     = (state_q == StMwT1) || (state_q == StMwT2) || (state_q == StMwT3);
    io_addr   = (mode_q == 3'd0) ? port_q : {b_q, c_q};
  end

  assign bus.addr      = io_ph ? io_addr : (mw_ph ? hl_q : 16'h0000);
  assign bus.iorq      = io_strobe;
  assign bus.rd        = io_strobe;
  assign bus.mreq      = mw_ph;
  assign bus.wr        = (state_q == StMwT2) || (state_q == StMwT3);
  assign bus.wdata     = mw_ph ? data_q : 8'h00;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.err       = (state_q == StDone) && err_q;
  assign bus.data_out  = data_q;
  assign bus.b_out     = b_q;
  assign bus.hl_out    = hl_q;
  assign bus.flags_out = flags_q;

endmodule

// File: tb/tb_z80_io_in_seq.sv
// Scoreboard bench for z80_io_in_seq: directed instructions push expected bus cycles and
// results; independent monitors pop and compare as the DUT presents them.
module tb_z80_io_in_seq;
  localparam int unsigned IoWait = 1;
  localparam int unsigned RptT   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  z80_io_in_seq_if bus ();

  z80_io_in_seq #(.IO_WAIT(IoWait), .RPT_T(RptT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  b;
    logic [15:0] hl;
    logic [7:0]  flags;
    logic        err;
    int          cyc;
    bit          full;
  } res_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          len;
  } cyc_t;

  res_t res_q[$];
  cyc_t io_q[$];
  cyc_t mw_q[$];

  int checks   = 0;
  int failures = 0;
  bit stretch  = 1'b0;
  bit glitch   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_io(input logic [15:0] a, input int len);
    cyc_t e;
    e.addr = a; e.data = 8'h00; e.len = len;
    io_q.push_back(e);
  endtask

  task automatic exp_mw(input logic [15:0] a, input logic [7:0] d, input int len);
    cyc_t e;
    e.addr = a; e.data = d; e.len = len;
    mw_q.push_back(e);
  endtask

  task automatic exp_res(input logic [7:0] d, input logic [7:0] b, input logic [15:0] hl,
                         input logic [7:0] f, input logic err, input int cyc, input bit full);
    res_t r;
    r.data = d; r.b = b; r.hl = hl; r.flags = f; r.err = err; r.cyc = cyc; r.full = full;
    res_q.push_back(r);
  endtask

  // Result monitor: cycle 1 is the state after the accepting edge.
  res_t r_cur;
  int   mon_cyc = 0;
  bit   mon_trk = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      mon_trk = 1'b0;
    end else begin
      if (mon_trk) mon_cyc++;
      if (bus.done) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          r_cur = res_q.pop_front();
          chk("done_cycle", 32'(mon_cyc), 32'(r_cur.cyc));
          chk("err", 32'(bus.err), 32'(r_cur.err));
          chk("busy_in_done", 32'(bus.busy), 32'd1);
          if (r_cur.full) begin
            chk("data_out", 32'(bus.data_out), 32'(r_cur.data));
            chk("b_out", 32'(bus.b_out), 32'(r_cur.b));
            chk("hl_out", 32'(bus.hl_out), 32'(r_cur.hl));
            chk("flags_out", 32'(bus.flags_out), 32'(r_cur.flags));
          end
        end
        mon_trk = 1'b0;
      end
      if (bus.start && !bus.busy) begin
        mon_trk = 1'b1;
        mon_cyc = 0;
      end
    end
  end

  cyc_t eio;
  int   io_len = 0;
  bit   io_act = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      io_act = 1'b0;
    end else if (bus.iorq && !io_act) begin
      io_act = 1'b1;
      io_len = 1;
      if (io_q.size() == 0) begin
        chk("unexpected_iorq", 32'(bus.iorq), 32'd0);
      end else begin
        eio = io_q.pop_front();
        chk("io_addr", 32'(bus.addr), 32'(eio.addr));
        chk("io_rd", 32'(bus.rd), 32'd1);
      end
    end else if (bus.iorq) begin
      io_len++;
    end else if (io_act) begin
      io_act = 1'b0;
      chk("io_strobe_len", 32'(io_len), 32'(eio.len));
    end
  end

  cyc_t emw;
  int   mw_len = 0;
  bit   mw_act = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      mw_act = 1'b0;
    end else if (bus.wr && !mw_act) begin
      mw_act = 1'b1;
      mw_len = 1;
      if (mw_q.size() == 0) begin
        chk("unexpected_wr", 32'(bus.wr), 32'd0);
      end else begin
        emw = mw_q.pop_front();
        chk("mw_addr", 32'(bus.addr), 32'(emw.addr));
        chk("mw_wdata", 32'(bus.wdata), 32'(emw.data));
        chk("mw_mreq", 32'(bus.mreq), 32'd1);
      end
    end else if (bus.wr) begin
      mw_len++;
    end else if (mw_act) begin
      mw_act = 1'b0;
      chk("wr_len", 32'(mw_len), 32'(emw.len));
    end
  end

  task automatic setup(input logic [2:0] m, input logic [7:0] a, input logic [7:0] n,
                       input logic [7:0] b, input logic [7:0] c, input logic [15:0] hl,
                       input logic [7:0] f, input logic [7:0] rdata);
    bus.mode = m; bus.a_in = a; bus.n = n; bus.b_in = b; bus.c_in = c;
    bus.hl_in = hl; bus.flags_in = f; bus.io_rdata = rdata;
  endtask

  task automatic issue();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic run();
    int c;
    issue();
    c = 1;
    forever begin
      bus.wait_n = !(stretch && (c == 3 || c == 4));
      if (glitch) bus.start = (c == 10);
      @(negedge clk);
      if (bus.done) break;
      if (c >= 5000) begin
        checks++; failures++;
        $display("FAIL done_timeout actual=no_done required=done");
        break;
      end
      @(posedge clk); #1 c++;
    end
    bus.start  = 1'b0;
    bus.wait_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {bus.addr, bus.iorq, bus.rd, bus.wr, bus.mreq, bus.busy, bus.done, bus.err,
               bus.wdata}, 32'd0);
    chk({name, "_regs"}, {bus.data_out, bus.b_out, bus.flags_out}, 32'd0);
    chk({name, "_hl"}, 32'(bus.hl_out), 32'd0);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus.start = 1'b0; bus.wait_n = 1'b1; bus.brk = 1'b0;
    setup(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 8'h00);
    #12;
    chk_all_zero("reset_state");
    @(negedge clk) reset = 1'b0;

    // IN A,(n)
    setup(3'd0, 8'h12, 8'h34, 8'h55, 8'h66, 16'hBEEF, 8'hC5, 8'hAB);
    exp_io(16'h1234, 3);
    exp_res(8'hAB, 8'h55, 16'hBEEF, 8'hC5, 1'b0, 5, 1'b1);
    run();

    // IN r,(C) with zero data: Z and even parity set, C kept
    setup(3'd1, 8'h00, 8'h00, 8'h01, 8'h80, 16'h1111, 8'h01, 8'h00);
    exp_io(16'h0180, 3);
    exp_res(8'h00, 8'h01, 16'h1111, 8'h45, 1'b0, 5, 1'b1);
    run();

    // IN r,(C) with negative data and junk flag bits to clear
    setup(3'd1, 8'h00, 8'h00, 8'h7F, 8'hFE, 16'h2222, 8'h3A, 8'h96);
    exp_io(16'h7FFE, 3);
    exp_res(8'h96, 8'h7F, 16'h2222, 8'h84, 1'b0, 5, 1'b1);
    run();

    // INI, B=1
    setup(3'd2, 8'h00, 8'h00, 8'h01, 8'h10, 16'h4000, 8'hFF, 8'h5A);
    exp_io(16'h0110, 3);
    exp_mw(16'h4000, 8'h5A, 2);
    exp_res(8'h5A, 8'h00, 16'h4001, 8'h43, 1'b0, 8, 1'b1);
    run();

    // IND with B and HL wrapping
    setup(3'd3, 8'h00, 8'h00, 8'h00, 8'h44, 16'h0000, 8'h01, 8'hE1);
    exp_io(16'h0044, 3);
    exp_mw(16'h0000, 8'hE1, 2);
    exp_res(8'hE1, 8'hFF, 16'hFFFF, 8'h83, 1'b0, 8, 1'b1);
    run();

    // INDR, B=3, with a start pulse while busy that must be ignored
    setup(3'd5, 8'h00, 8'h00, 8'h03, 8'h20, 16'h4002, 8'h00, 8'h77);
    exp_io(16'h0320, 3); exp_mw(16'h4002, 8'h77, 2);
    exp_io(16'h0220, 3); exp_mw(16'h4001, 8'h77, 2);
    exp_io(16'h0120, 3); exp_mw(16'h4000, 8'h77, 2);
    exp_res(8'h77, 8'h00, 16'h3FFF, 8'h42, 1'b0, 32, 1'b1);
    glitch = 1'b1;
    run();
    glitch = 1'b0;

    // INIR, B=3, interrupted by brk after the first write
    setup(3'd4, 8'h00, 8'h00, 8'h03, 8'h05, 16'h1000, 8'h81, 8'hC3);
    exp_io(16'h0305, 3);
    exp_mw(16'h1000, 8'hC3, 2);
    exp_res(8'hC3, 8'h02, 16'h1001, 8'h03, 1'b0, 8, 1'b1);
    bus.brk = 1'b1;
    run();
    bus.brk = 1'b0;

    // IN A,(n) with WAIT held low two cycles in TW: 6-cycle I/O
    setup(3'd0, 8'h9A, 8'hBC, 8'h00, 8'h00, 16'h0000, 8'h00, 8'h01);
    exp_io(16'h9ABC, 5);
    exp_res(8'h01, 8'h00, 16'h0000, 8'h00, 1'b0, 7, 1'b1);
    stretch = 1'b1;
    run();
    stretch = 1'b0;

    // INDR with B=0: 256 iterations
    setup(3'd5, 8'h00, 8'h00, 8'h00, 8'h01, 16'h8000, 8'h00, 8'h3C);
    for (k = 0; k < 256; k++) begin
      exp_io({8'(0 - k), 8'h01}, 3);
      exp_mw(16'(32'h8000 - k), 8'h3C, 2);
    end
    exp_res(8'h3C, 8'h00, 16'h7F00, 8'h42, 1'b0, 256 * 7 + 255 * RptT + 1, 1'b1);
    run();

    // Illegal mode: done+err in cycle 1, no bus cycles
    setup(3'd7, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 8'h00);
    exp_res(8'h00, 8'h00, 16'h0000, 8'h00, 1'b1, 1, 1'b0);
    run();

    // Reset during MW_T2 of an INI
    setup(3'd2, 8'h00, 8'h00, 8'h01, 8'h10, 16'h4000, 8'h00, 8'h5A);
    exp_io(16'h0110, 3);
    exp_mw(16'h4000, 8'h5A, 2);
    issue();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.wr && k < 20);
    if (!bus.wr) begin
      checks++; failures++;
      $display("FAIL wr_timeout actual=no_wr required=wr");
    end
    #1 reset = 1'b1;
    #1 chk_all_zero("reset_mid_write");
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(bus.busy), 32'd0);

    // Normal operation after the abort
    setup(3'd0, 8'h00, 8'hFF, 8'h11, 8'h22, 16'h3333, 8'h10, 8'h5A);
    exp_io(16'h00FF, 3);
    exp_res(8'h5A, 8'h11, 16'h3333, 8'h10, 1'b0, 5, 1'b1);
    run();

    repeat (4) @(negedge clk);
    chk("pending_expectations", 32'(io_q.size() + mw_q.size() + res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/z80_io_in_seq.md
# z80_io_in_seq

Multi-cycle sequencer for Z80 input instructions: IN A,(n), IN r,(C), INI, IND, INIR and INDR. It is the T-state-accurate successor to the single-instruction IN A,(n) behaviour. It drives the I/O read and memory write bus cycles itself, honours WAIT, and loops the repeating block forms internally. It sits between the core's execute stage and the external bus interface; one clk equals one T-state.

## Interface
- IO_WAIT, 1, automatic wait T-states inserted in every I/O read cycle (legal 0..3)
- RPT_T, 5, internal T-states between iterations of INIR/INDR (legal 1..15)

- clk  in  1  T-state clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin instruction; sampled only in IDLE
- mode  in  3  0 IN_A_N, 1 IN_R_C, 2 INI, 3 IND, 4 INIR, 5 INDR, 6-7 illegal
- n  in  8  immediate port byte (mode 0)
- a_in, b_in, c_in  in  8 each  register values at start
- hl_in  in  16  HL at start
- flags_in  in  8  F at start (S Z 5 H 3 PV N C)
- wait_n  in  1  bus WAIT, active low
- brk  in  1  interrupt pending; terminates a repeat loop early
- io_rdata  in  8  I/O read data
- addr  out  16  bus address
- iorq, rd, wr, mreq  out  1 each  active-high bus strobes
- wdata  out  8  memory write data
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- err  out  1  high with done for illegal mode
- data_out  out  8  last byte read
- b_out  out  8  final B
- hl_out  out  16  final HL
- flags_out  out  8  final F

## Operation
- States: IDLE, IO_T1, IO_T2, IO_TW, IO_T3, MW_T1, MW_T2, MW_T3, RPT, DONE.
- IDLE + start: latch inputs, go to IO_T1. For illegal modes, go straight to DONE with err=1 and no bus activity.
- I/O address: mode 0 uses {a_in, n}. All other modes use {B, C}, with B taken before decrement.
- IO_T1: addr valid, strobes low.
- IO_T2: iorq and rd high.
- IO_TW: counts IO_WAIT cycles. It stays in IO_TW beyond the count while wait_n=0 is sampled in the last counted TW. With IO_WAIT=0, wait_n is sampled in IO_T2 instead.
- IO_T3: iorq and rd stay high. io_rdata is latched into data_out on the edge ending IO_T3.
- Modes 0 and 1 go from IO_T3 to DONE.
- Modes 2-5 go from IO_T3 to MW_T1:
  - addr=HL and wdata=data read.
  - mreq high in MW_T1..MW_T3; wr high in MW_T2..MW_T3.
  - wait_n=0 sampled in MW_T2 holds MW_T2.
- End of MW_T3: B←B-1 (8-bit wrap) and HL←HL±1 (16-bit wrap; + for INI/INIR, - for IND/INDR).
- Repeat modes (4, 5): if the new B≠0 and brk=0, go to RPT for RPT_T cycles, then IO_T1. Otherwise go to DONE.
- B=0 at start of INIR/INDR performs 256 iterations.
- Flags:
  - Mode 0: flags_out=flags_in.
  - Mode 1: S=d[7], Z=(d==0), H=0, PV=even parity of d, N=0, bits 5 and 3 cleared, C preserved.
  - Modes 2-5: S=newB[7], Z=(newB==0), H=0, PV=0, N=1, bits 5 and 3 cleared, C preserved.
- Mode 1 register destination is chosen by the core; this block only returns data_out.

## Timing
- Reset values: all strobes 0, addr 0, wdata 0, busy 0, done 0, err 0, data_out 0, b_out 0, hl_out 0, flags_out 0, state IDLE.
- Reset mid-instruction aborts immediately; no strobe survives the reset assertion.
- IO_T1 follows the start cycle.
- I/O cycle length is 3+IO_WAIT+extra waits.
- Memory write cycle is 3+extra waits.
- DONE lasts one cycle with done=1 and busy=1; IDLE follows.
- Result outputs are valid in DONE and held until the next start is accepted.
- start during busy is ignored.
- brk is sampled only on the edge ending MW_T3. It has no effect on non-repeat modes.

## Test plan
- Mode 0, A=0x12, n=0x34, io_rdata=0xAB, IO_WAIT=1 -> addr=0x1234 for 4 cycles, iorq/rd high in cycles 2-4, done in cycle 5, data_out=0xAB, flags_out=flags_in.
- Mode 1, B=0x01, C=0x80, io_rdata=0x00, flags_in=0x01 -> addr=0x0180, flags_out=0x45.
- Mode 2, B=1, C=0x10, HL=0x4000, io_rdata=0x5A -> I/O at 0x0110, then memory write of 0x5A to 0x4000 with wr high 2 cycles, done at cycle 8, b_out=0, hl_out=0x4001, Z=1, N=1.
- Mode 5, B=3, HL=0x4002 -> writes at 0x4002, 0x4001, 0x4000 with two 5-cycle RPT gaps, done at cycle 32, hl_out=0x3FFF, b_out=0.
- Mode 4, B=3, brk=1 during the first MW_T3 -> single iteration, b_out=2, hl_out=HL+1, Z=0. Separately, wait_n low for 2 cycles in IO_TW -> I/O cycle stretched to 6 cycles.
- Mode 7 -> done and err at cycle 1, no strobes. Separately, reset asserted in MW_T2 -> all outputs zero that cycle, IDLE afterwards.
